// File: rtl/chargen_sink.sv
// Read-side consumer for the character-generator FIFO path: drains an FT245-style
// read port and checks the bytes against the repeating FIRSTCHAR..LASTCHAR cycle.
module chargen_sink #(
  parameter logic [7:0]  FIRSTCHAR = 8'h61,
  parameter logic [7:0]  LASTCHAR  = 8'h7a,
  parameter int unsigned RD_WAIT   = 2,
  parameter int unsigned ERRW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0]      port,
  input  logic            n_rxf,
  output logic            n_rd,
  output logic [7:0]      data,
  output logic            data_valid,
  output logic            err,
  output logic [ERRW-1:0] err_count,
  output logic            locked
);

  localparam int unsigned     WAITW     = 4;
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(RD_WAIT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, SAMPLE, RECOVER} state_t;

  state_t            state, state_n;
  logic [WAITW-1:0]  wait_cnt, wait_cnt_n;
  logic              rxf_meta, rxf_s;
  logic [7:0]        expected, expected_n;
  logic              prev_ok, prev_ok_n;
  logic              n_rd_n;
  logic [7:0]        data_n;
  logic              data_valid_n;
  logic              err_n;
  logic [ERRW-1:0]   err_count_n;
  logic              locked_n;

  function automatic logic [7:0] succ(input logic [7:0] b);
    return (b == LASTCHAR) ? FIRSTCHAR : b + 8'd1;
  endfunction

  // n_rxf is asynchronous to clk; only rxf_s is used downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_meta <= 1'b1;
      rxf_s    <= 1'b1;
    end else begin
      rxf_meta <= n_rxf;
      rxf_s    <= rxf_meta;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      expected   <= FIRSTCHAR;
      prev_ok    <= 1'b0;
      n_rd       <= 1'b1;
      data       <= 8'h00;
      data_valid <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      expected   <= expected_n;
      prev_ok    <= prev_ok_n;
      n_rd       <= n_rd_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      err        <= err_n;
      err_count  <= err_count_n;
      locked     <= locked_n;
    end
  end

  // Read sequencing and sequence checker; the byte is captured on the edge that
  // ends the strobe, so data/data_valid/err appear during SAMPLE
  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    expected_n   = expected;
    prev_ok_n    = prev_ok;
    n_rd_n       = n_rd;
    data_n       = data;
    data_valid_n = 1'b0;
    err_n        = 1'b0;
    err_count_n  = err_count;
    locked_n     = locked;

    unique case (state)
      IDLE: begin
        if (en && !rxf_s) begin
          state_n    = STROBE;
          n_rd_n     = 1'b0;
          wait_cnt_n = '0;
        end
      end
      STROBE: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n      = SAMPLE;
          n_rd_n       = 1'b1;
          data_n       = port;
          data_valid_n = 1'b1;
          if (port == expected) begin
            expected_n = succ(port);
            locked_n   = prev_ok;
            prev_ok_n  = 1'b1;
          end else begin
            err_n    = 1'b1;
            locked_n = 1'b0;
            if (err_count != '1) err_count_n = err_count + ERRW'(1);
            // An in-range byte still anchors the sequence, so it can count
            // towards re-locking on the next byte
            if (port >= FIRSTCHAR && port <= LASTCHAR) begin
              expected_n = succ(port);
              prev_ok_n  = 1'b1;
            end else begin
              expected_n = FIRSTCHAR;
              prev_ok_n  = 1'b0;
            end
          end
        end else begin
          wait_cnt_n = wait_cnt + WAITW'(1);
        end
      end
      SAMPLE:  state_n = RECOVER;
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
